// File: rtl/bbox_pkg.sv
// Shared constants, register map and types for the marker bounding-box tracker.
// Frame geometry here is the default; the top level can override it per instance.
package bbox_pkg;

    localparam int          IMAGE_W  = 640;
    localparam int          IMAGE_H  = 480;
    localparam logic [23:0] MARK_RGB = 24'h00FF00;

    localparam int XW = 11;
    localparam int YW = 11;
    localparam int CW = 20;

    localparam logic [2:0] ADDR_MIN    = 3'd0;
    localparam logic [2:0] ADDR_MAX    = 3'd1;
    localparam logic [2:0] ADDR_COUNT  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    localparam int ST_DONE    = 0;
    localparam int ST_VALID   = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_RESTART = 3;
    localparam int ST_SHORT   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x_min;
        logic [YW-1:0] y_min;
        logic [XW-1:0] x_max;
        logic [YW-1:0] y_max;
    } box_t;

endpackage

// File: rtl/bbox_tracker_pos.sv
// X/Y position of the beat currently on the sink, with sop reload, line wrap,
// last-pixel detection and an overrun indication for beats past the frame end.
module pixel_pos_counter #(
    parameter int IMAGE_W = bbox_pkg::IMAGE_W,
    parameter int IMAGE_H = bbox_pkg::IMAGE_H
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat,
    input  logic                   sop,
    input  logic                   eop,
    output logic [bbox_pkg::XW-1:0] x,
    output logic [bbox_pkg::YW-1:0] y,
    output logic                   last,
    output logic                   overrun
);
    import bbox_pkg::*;

    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);

    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          past_end;

    // The registers hold where the next beat lands; a sop beat is always (0,0).
    assign x       = sop ? '0 : x_next;
    assign y       = sop ? '0 : y_next;
    assign last    = (x == X_LAST) && (y == Y_LAST);
    assign overrun = past_end && !sop;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_next   <= '0;
            y_next   <= '0;
            past_end <= 1'b0;
        end else if (beat) begin
            past_end <= overrun || (last && !eop);
            if (!overrun) begin
                if (x == X_LAST) begin
                    x_next <= '0;
                    y_next <= y + 1'b1;
                end else begin
                    x_next <= x + 1'b1;
                    y_next <= y;
                end
            end
        end
    end

endmodule

// File: rtl/bbox_tracker.sv
// RGB stream pass-through with one register stage that accumulates a per-frame
// bounding box and hit count of marker-coloured pixels, readable over Avalon-MM.
module bbox_tracker #(
    parameter int          IMAGE_W  = bbox_pkg::IMAGE_W,
    parameter int          IMAGE_H  = bbox_pkg::IMAGE_H,
    parameter logic [23:0] MARK_RGB = bbox_pkg::MARK_RGB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_chipselect,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [2:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    output logic        sink_ready,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic [23:0] source_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic        source_sop,
    output logic        source_eop
);
    import bbox_pkg::*;

    localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMAGE_H - 1);
    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic          beat;
    logic          hit;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          pos_last;
    logic          pos_overrun;

    state_t state;
    state_t state_next;
    logic   acc_load;
    logic   acc_update;
    logic   frame_end;
    logic   set_restart;
    logic   set_overrun;
    logic   set_short;

    box_t          acc_box;
    logic [CW-1:0] acc_count;
    box_t          shadow_box;
    logic [CW-1:0] shadow_count;
    logic          latch_pending;

    logic          enable;
    logic          frame_done;
    logic          box_valid;
    logic          overrun_flag;
    logic          restart_flag;
    logic          short_flag;
    logic [15:0]   frame_cnt;

    logic          mm_wr;
    logic          w1c;
    logic [31:0]   status;
    logic [31:0]   read_mux;
    logic          unused_wdata;

    // ---------------- stream pass-through ----------------
    assign sink_ready = source_ready || !source_valid;
    assign beat       = sink_valid && sink_ready;
    assign hit        = enable && (sink_data == MARK_RGB);

    always_ff @(posedge clk) begin
        if (reset) begin
            source_valid <= 1'b0;
        end else if (beat) begin
            source_valid <= 1'b1;
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; source_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (beat) begin
            source_data <= sink_data;
            source_sop  <= sink_sop;
            source_eop  <= sink_eop;
        end
    end

    pixel_pos_counter #(
        .IMAGE_W (IMAGE_W),
        .IMAGE_H (IMAGE_H)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .beat    (beat),
        .sop     (sink_sop),
        .eop     (sink_eop),
        .x       (pos_x),
        .y       (pos_y),
        .last    (pos_last),
        .overrun (pos_overrun)
    );

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        if (beat) begin
            case (state)
                S_IDLE, S_DROP: begin
                    if (sink_sop) state_next = sink_eop ? S_IDLE : S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (sink_sop)         state_next = sink_eop ? S_IDLE : S_ACTIVE;
                    else if (pos_overrun) state_next = S_DROP;
                    else if (sink_eop)    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_load    = 1'b0;
        acc_update  = 1'b0;
        frame_end   = 1'b0;
        set_restart = 1'b0;
        set_overrun = 1'b0;
        if (beat) begin
            if (sink_sop) begin
                acc_load    = 1'b1;
                frame_end   = sink_eop;
                set_restart = (state == S_ACTIVE);
            end else if (state == S_ACTIVE) begin
                if (pos_overrun) begin
                    set_overrun = 1'b1;
                end else begin
                    acc_update = 1'b1;
                    frame_end  = sink_eop;
                end
            end
        end
    end

    assign set_short = frame_end && !pos_last;

    // ---------------- accumulators ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_box   <= '0;
            acc_count <= '0;
        end else if (acc_load) begin
            if (hit) begin
                acc_box   <= '0;
                acc_count <= CW'(1);
            end else begin
                acc_box.x_min <= X_LAST;
                acc_box.y_min <= Y_LAST;
                acc_box.x_max <= '0;
                acc_box.y_max <= '0;
                acc_count     <= '0;
            end
        end else if (acc_update && hit) begin
            if (pos_x < acc_box.x_min) acc_box.x_min <= pos_x;
            if (pos_y < acc_box.y_min) acc_box.y_min <= pos_y;
            if (pos_x > acc_box.x_max) acc_box.x_max <= pos_x;
            if (pos_y > acc_box.y_max) acc_box.y_max <= pos_y;
            if (acc_count != COUNT_MAX) acc_count <= acc_count + 1'b1;
        end
    end

    // ---------------- result latch and status ----------------
    assign mm_wr        = s_chipselect && s_write;
    assign w1c          = mm_wr && (s_address == ADDR_STATUS) && s_writedata[0];
    assign unused_wdata = ^s_writedata[31:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_pending <= 1'b0;
            shadow_box    <= '0;
            shadow_count  <= '0;
            box_valid     <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            latch_pending <= frame_end;
            if (latch_pending) begin
                frame_done   <= 1'b1;
                frame_cnt    <= frame_cnt + 1'b1;
                box_valid    <= (acc_count != '0);
                shadow_count <= acc_count;
                shadow_box   <= (acc_count != '0) ? acc_box : '0;
            end else if (w1c) begin
                frame_done <= 1'b0;
            end
        end
    end

    // Setting a sticky flag wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_flag <= 1'b0;
            restart_flag <= 1'b0;
            short_flag   <= 1'b0;
            enable       <= 1'b1;
        end else begin
            if (set_overrun)  overrun_flag <= 1'b1;
            else if (w1c)     overrun_flag <= 1'b0;
            if (set_restart)  restart_flag <= 1'b1;
            else if (w1c)     restart_flag <= 1'b0;
            if (set_short)    short_flag   <= 1'b1;
            else if (w1c)     short_flag   <= 1'b0;
            if (mm_wr && (s_address == ADDR_CTRL)) enable <= s_writedata[0];
        end
    end

    // ---------------- MM read path ----------------
    always_comb begin
        status             = '0;
        status[31:16]      = frame_cnt;
        status[ST_DONE]    = frame_done;
        status[ST_VALID]   = box_valid;
        status[ST_OVERRUN] = overrun_flag;
        status[ST_RESTART] = restart_flag;
        status[ST_SHORT]   = short_flag;
    end

    always_comb begin
        read_mux = '0;
        case (s_address)
            ADDR_MIN:    read_mux = {5'b0, shadow_box.x_min, 5'b0, shadow_box.y_min};
            ADDR_MAX:    read_mux = {5'b0, shadow_box.x_max, 5'b0, shadow_box.y_max};
            ADDR_COUNT:  read_mux = {12'b0, shadow_count};
            ADDR_STATUS: read_mux = status;
            ADDR_CTRL:   read_mux = {31'b0, enable};
            default:     read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_readdata <= '0;
        end else if (s_chipselect && s_read) begin
            s_readdata <= read_mux;
        end
    end

endmodule
